// File: rtl/nn_layer_sched_if.sv
// Valid/ready stream carrying one signed T-bit element per beat.
// The master drives valid/data and the slave drives ready.
interface nn_layer_sched_if #(
    parameter int unsigned T = 12
);
    logic         valid;
    logic         ready;
    logic [T-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/nn_layer_sched.sv
// Fully-connected layer sequencer: loads x, streams M x N operands to a shared MAC,
// and returns ReLU(row result) per row over a valid/ready master port.
module nn_layer_sched #(
    parameter int unsigned M  = 8,
    parameter int unsigned N  = 8,
    parameter int unsigned T  = 12,
    parameter int unsigned WA = $clog2(M*N),
    parameter int unsigned BA = $clog2(M),
    parameter int unsigned XA = $clog2(N)
) (
    input  logic              clk,
    input  logic              reset,
    nn_layer_sched_if.slave   s_if,
    output logic [T-1:0]      x_wdata,
    output logic              x_wr_en,
    output logic [XA-1:0]     x_addr,
    output logic [WA-1:0]     w_addr,
    output logic [BA-1:0]     b_addr,
    output logic              mac_valid_in,
    input  logic [T-1:0]      mac_f,
    input  logic              mac_valid_out,
    nn_layer_sched_if.master  m_if,
    output logic              err
);
    localparam logic [XA-1:0] LAST_COL = XA'(N - 1);
    localparam logic [BA-1:0] LAST_ROW = BA'(M - 1);

    typedef enum logic [1:0] {LOAD, ISSUE, WAIT, OUT} state_t;

    state_t        state, state_d;
    logic [XA-1:0] wr_cnt, wr_cnt_d;
    logic [XA-1:0] rd_cnt, rd_cnt_d;
    logic [BA-1:0] row, row_d;
    logic          m_valid_q, m_valid_d;
    logic [T-1:0]  data_out_q, data_out_d;
    logic          err_d;
    logic          issue_en;
    logic          s_ready_c;

    assign x_wdata   = s_if.data;
    assign s_if.ready = s_ready_c;
    assign m_if.valid = m_valid_q;
    assign m_if.data  = data_out_q;

    // Operand addresses follow the counters directly; the ROMs see them one cycle before mac_valid_in.
    assign w_addr = WA'(row) * WA'(N) + WA'(rd_cnt);
    assign b_addr = row;

    always_comb begin
        state_d    = state;
        wr_cnt_d   = wr_cnt;
        rd_cnt_d   = rd_cnt;
        row_d      = row;
        m_valid_d  = m_valid_q;
        data_out_d = data_out_q;
        err_d      = err | (mac_valid_out && (state != WAIT));
        issue_en   = 1'b0;
        s_ready_c  = 1'b0;
        x_wr_en    = 1'b0;
        x_addr     = '0;

        case (state)
            LOAD: begin
                s_ready_c = 1'b1;
                x_wr_en   = s_if.valid;
                x_addr    = wr_cnt;
                if (s_if.valid) begin
                    if (wr_cnt == LAST_COL) begin
                        wr_cnt_d = '0;
                        rd_cnt_d = '0;
                        row_d    = '0;
                        state_d  = ISSUE;
                    end else begin
                        wr_cnt_d = wr_cnt + XA'(1);
                    end
                end
            end
            ISSUE: begin
                issue_en = 1'b1;
                x_addr   = rd_cnt;
                if (rd_cnt == LAST_COL) begin
                    rd_cnt_d = '0;
                    state_d  = WAIT;
                end else begin
                    rd_cnt_d = rd_cnt + XA'(1);
                end
            end
            WAIT: begin
                if (mac_valid_out) begin
                    data_out_d = mac_f[T-1] ? '0 : mac_f;
                    m_valid_d  = 1'b1;
                    state_d    = OUT;
                end
            end
            OUT: begin
                // A new row is only issued once the current result has been taken.
                if (m_if.ready) begin
                    m_valid_d = 1'b0;
                    if (row == LAST_ROW) begin
                        row_d   = '0;
                        state_d = LOAD;
                    end else begin
                        row_d   = row + BA'(1);
                        state_d = ISSUE;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= LOAD;
            wr_cnt       <= '0;
            rd_cnt       <= '0;
            row          <= '0;
            m_valid_q    <= 1'b0;
            data_out_q   <= '0;
            mac_valid_in <= 1'b0;
            err          <= 1'b0;
        end else begin
            state        <= state_d;
            wr_cnt       <= wr_cnt_d;
            rd_cnt       <= rd_cnt_d;
            row          <= row_d;
            m_valid_q    <= m_valid_d;
            data_out_q   <= data_out_d;
            mac_valid_in <= issue_en;
            err          <= err_d;
        end
    end
endmodule

// File: tb/tb_nn_layer_sched.sv
// Bench for nn_layer_sched: memory models, a 2-cycle MAC stub and a sum-of-products
// reference for each row result.
module tb_nn_layer_sched;
    localparam int unsigned M   = 2;
    localparam int unsigned N   = 3;
    localparam int unsigned T   = 12;
    localparam int unsigned WA  = $clog2(M*N);
    localparam int unsigned BA  = $clog2(M);
    localparam int unsigned XA  = $clog2(N);
    localparam int unsigned LAT = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          s_valid = 1'b0;
    logic          m_ready = 1'b0;
    logic          inject = 1'b0;
    logic [T-1:0]  data_in = '0;
    logic          s_ready, m_valid;
    logic [T-1:0]  data_out, x_wdata, mac_f;
    logic          x_wr_en, mac_valid_in, mac_valid_out, err;
    logic [XA-1:0] x_addr;
    logic [WA-1:0] w_addr;
    logic [BA-1:0] b_addr;

    int checks = 0;
    int errors = 0;

    nn_layer_sched_if #(.T(T)) s_if ();
    nn_layer_sched_if #(.T(T)) m_if ();

    assign s_if.valid = s_valid;
    assign s_if.data  = data_in;
    assign s_ready    = s_if.ready;
    assign m_if.ready = m_ready;
    assign m_valid    = m_if.valid;
    assign data_out   = m_if.data;

    nn_layer_sched #(.M(M), .N(N), .T(T)) dut (
        .clk(clk), .reset(reset), .s_if(s_if),
        .x_wdata(x_wdata), .x_wr_en(x_wr_en), .x_addr(x_addr),
        .w_addr(w_addr), .b_addr(b_addr), .mac_valid_in(mac_valid_in),
        .mac_f(mac_f), .mac_valid_out(mac_valid_out), .m_if(m_if), .err(err)
    );

    always #5 clk = ~clk;

    // Memories with one cycle of read latency
    logic signed [T-1:0] x_ram [2**XA];
    int w_rom [2**WA];
    int b_rom [2**BA];
    int x_q, w_q, b_q;
    int x_vec [N];

    always @(posedge clk) begin
        x_q <= x_ram[x_addr];
        w_q <= w_rom[w_addr];
        b_q <= b_rom[b_addr];
        if (x_wr_en) x_ram[x_addr] <= x_wdata;
    end

    // MAC stub: accumulate N beats, then report the sum LAT cycles after the last beat
    int acc, beat;
    logic [LAT-1:0] fire;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            acc  <= 0;
            beat <= 0;
            fire <= '0;
        end else begin
            fire <= {fire[LAT-2:0], mac_valid_in && (beat == N-1)};
            if (mac_valid_in) begin
                acc  <= ((beat == 0) ? b_q : acc) + x_q * w_q;
                beat <= (beat == N-1) ? 0 : beat + 1;
            end
        end
    end
    assign mac_valid_out = fire[LAT-1] | inject;
    assign mac_f = T'(acc);

    function automatic logic [T-1:0] ref_row(input int r);
        int s;
        logic signed [T-1:0] t;
        s = b_rom[r];
        for (int j = 0; j < N; j++) s += x_vec[j] * w_rom[r*N + j];
        t = T'(s);
        return (t < 0) ? '0 : t;
    endfunction

    task automatic randomize_layer();
        for (int i = 0; i < 2**WA; i++) w_rom[i] = (i < M*N) ? int'($urandom_range(0, 40)) - 20 : 0;
        for (int i = 0; i < 2**BA; i++) b_rom[i] = (i < M) ? int'($urandom_range(0, 400)) - 200 : 0;
        for (int j = 0; j < N; j++) x_vec[j] = int'($urandom_range(0, 100)) - 50;
    endtask

    // Streams x_vec in with random idle gaps; returns at the first ISSUE cycle (+1ns)
    task automatic load_vec(input int gap_max);
        for (int j = 0; j < N; j++) begin
            repeat ($urandom_range(0, gap_max)) begin
                @(negedge clk); s_valid = 1'b0; data_in = T'($urandom); #1;
                checks++;
                if (x_wr_en !== 1'b0 || s_ready !== 1'b1)
                    begin errors++; $display("FAIL load_idle: x_wr_en=%b s_ready=%b want 0/1", x_wr_en, s_ready); end
            end
            @(negedge clk); s_valid = 1'b1; data_in = T'(x_vec[j]); #1;
            checks++;
            if (x_wr_en !== 1'b1 || x_addr !== XA'(j) || x_wdata !== data_in || s_ready !== 1'b1)
                begin errors++; $display("FAIL load_beat%0d: wr_en=%b addr=%0d wdata=%h ready=%b want 1/%0d/%h/1", j, x_wr_en, x_addr, x_wdata, s_ready, j, data_in); end
        end
        @(negedge clk); data_in = T'($urandom); #1;
        checks++;
        if (s_ready !== 1'b0 || x_wr_en !== 1'b0 || w_addr !== '0 || b_addr !== '0 || mac_valid_in !== 1'b0)
            begin errors++; $display("FAIL issue_start: ready=%b wr_en=%b w=%0d b=%0d mvi=%b want 0/0/0/0/0", s_ready, x_wr_en, w_addr, b_addr, mac_valid_in); end
        s_valid = 1'b0;
    endtask

    // Waits for row r, checks it, stalls 'stall' cycles, accepts, checks the following cycle
    task automatic get_row(input int r, input int stall);
        int n;
        logic [T-1:0] exp_v, held;
        n = 0;
        m_ready = 1'b0;
        exp_v = ref_row(r);
        while (m_valid !== 1'b1 && n < 100) begin @(negedge clk); #1; n++; end
        checks++;
        if (m_valid !== 1'b1) begin errors++; $display("FAIL row%0d_timeout: m_valid=%b want 1", r, m_valid); return; end
        checks++;
        if (data_out !== exp_v) begin errors++; $display("FAIL row%0d_data: got %0d want %0d", r, $signed(data_out), $signed(exp_v)); end
        held = data_out;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk); #1;
            checks++;
            if (m_valid !== 1'b1 || data_out !== held || mac_valid_in !== 1'b0 || w_addr !== WA'(r*N))
                begin errors++; $display("FAIL row%0d_stall%0d: m_valid=%b data=%0d mvi=%b w=%0d want 1/%0d/0/%0d", r, s, m_valid, data_out, mac_valid_in, w_addr, held, r*N); end
        end
        @(negedge clk); m_ready = 1'b1;
        @(negedge clk); m_ready = 1'b0; #1;
        checks++;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL row%0d_accept: m_valid=%b want 0", r, m_valid); end
        checks++;
        if (r < M-1) begin
            if (w_addr !== WA'((r+1)*N) || b_addr !== BA'(r+1) || s_ready !== 1'b0)
                begin errors++; $display("FAIL row%0d_next_issue: w=%0d b=%0d ready=%b want %0d/%0d/0", r, w_addr, b_addr, s_ready, (r+1)*N, r+1); end
        end else if (s_ready !== 1'b1) begin
            errors++; $display("FAIL row%0d_back_to_load: s_ready=%b want 1", r, s_ready);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({s_ready, m_valid, mac_valid_in, err} !== 4'b1000 || data_out !== '0)
            begin errors++; $display("FAIL reset_ctrl: rdy/mv/mvi/err=%b data=%0d want 1000/0", {s_ready, m_valid, mac_valid_in, err}, data_out); end
        checks++;
        if (x_addr !== '0 || w_addr !== '0 || b_addr !== '0)
            begin errors++; $display("FAIL reset_addr: x=%0d w=%0d b=%0d want 0/0/0", x_addr, w_addr, b_addr); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_directed();
        int mvi_cnt;
        x_vec = '{1, 2, 3};
        w_rom = '{0, 0, 0, 1, 2, 3, 0, 0};
        b_rom = '{-7, 11};
        load_vec(0);
        mvi_cnt = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk); #1;
            if (mac_valid_in === 1'b1) mvi_cnt++;
            checks++;
            if (mac_valid_in !== ((k <= 3) ? 1'b1 : 1'b0))
                begin errors++; $display("FAIL row0_mvi_k%0d: got %b want %b", k, mac_valid_in, (k <= 3)); end
            if (k < 3) begin
                checks++;
                if (w_addr !== WA'(k) || b_addr !== '0)
                    begin errors++; $display("FAIL row0_addr_k%0d: w=%0d b=%0d want %0d/0", k, w_addr, b_addr, k); end
            end
        end
        checks++;
        if (mvi_cnt != 3) begin errors++; $display("FAIL row0_mvi_count: got %0d want 3", mvi_cnt); end
        get_row(0, 10);
        for (int k = 1; k < N; k++) begin
            @(negedge clk); #1;
            checks++;
            if (w_addr !== WA'(N + k) || b_addr !== BA'(1))
                begin errors++; $display("FAIL row1_addr_k%0d: w=%0d b=%0d want %0d/1", k, w_addr, b_addr, N + k); end
        end
        get_row(1, 0);
    endtask

    task automatic test_err();
        @(negedge clk); inject = 1'b1;
        @(negedge clk); inject = 1'b0; #1;
        checks++;
        if (err !== 1'b1 || s_ready !== 1'b1) begin errors++; $display("FAIL err_set: err=%b ready=%b want 1/1", err, s_ready); end
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: err=%b want 1", err); end
        @(negedge clk); reset = 1'b1; #1;
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL err_clear: err=%b want 0", err); end
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_reset_mid_issue();
        randomize_layer();
        load_vec(1);
        get_row(0, 0);
        @(negedge clk); #1;
        checks++;
        if (w_addr !== WA'(N + 1) || mac_valid_in !== 1'b1)
            begin errors++; $display("FAIL mid_issue_pre: w=%0d mvi=%b want %0d/1", w_addr, mac_valid_in, N + 1); end
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({s_ready, m_valid, mac_valid_in, err} !== 4'b1000 || data_out !== '0)
            begin errors++; $display("FAIL mid_reset_ctrl: rdy/mv/mvi/err=%b data=%0d want 1000/0", {s_ready, m_valid, mac_valid_in, err}, data_out); end
        checks++;
        if (x_addr !== '0 || w_addr !== '0 || b_addr !== '0)
            begin errors++; $display("FAIL mid_reset_addr: x=%0d w=%0d b=%0d want 0/0/0", x_addr, w_addr, b_addr); end
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_random_layer(input int gap_max, input int stall_max);
        randomize_layer();
        load_vec(gap_max);
        for (int r = 0; r < M; r++) get_row(r, $urandom_range(0, stall_max));
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL random_err: err=%b want 0", err); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_err();
        test_reset_mid_issue();
        for (int i = 0; i < 8; i++) test_random_layer(3, 4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
